// File: rtl/psum_rmw_accumulator.sv
// Read-modify-write front end for the psum SRAM bank: accumulates col-lane partial sums
// into the bank and drains address ranges back out with per-lane ReLU.
module psum_rmw_accumulator #(
  parameter int col     = 8,
  parameter int psum_bw = 32,
  parameter int addr_bw = 11
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [addr_bw-1:0]       in_addr,
  input  logic                     in_first,
  input  logic [psum_bw*col-1:0]   in_data,
  input  logic                     drain_start,
  input  logic [addr_bw-1:0]       drain_base,
  input  logic [addr_bw:0]         drain_len,
  output logic                     out_valid,
  output logic [addr_bw-1:0]       out_addr,
  output logic [psum_bw*col-1:0]   out_data,
  output logic                     drain_done,
  output logic                     busy,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_bw-1:0]       sram_a,
  output logic [psum_bw*col-1:0]   sram_d,
  input  logic [psum_bw*col-1:0]   sram_q
);

  localparam int WORD_W = psum_bw * col;

  typedef enum logic [1:0] {IDLE, ACC_WR, DRAIN, DRAIN_LAST} state_t;

  state_t                state_q, state_d;
  logic                  rdy_q;
  logic [addr_bw-1:0]    rd_addr_q, rd_addr_d;
  logic [addr_bw:0]      cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [addr_bw-1:0]    out_addr_q, out_addr_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic [addr_bw-1:0]    addr_q;
  logic                  first_q;
  logic [WORD_W-1:0]     data_q;

  // Lane-wise add with natural two's-complement wrap; first pass ignores the stored word.
  function automatic logic [WORD_W-1:0] acc_word(input logic [WORD_W-1:0] q,
                                                 input logic [WORD_W-1:0] d,
                                                 input logic              first);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < col; i++) begin
      r[i*psum_bw +: psum_bw] = (first ? '0 : q[i*psum_bw +: psum_bw]) + d[i*psum_bw +: psum_bw];
    end
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] relu_word(input logic [WORD_W-1:0] q);
    logic [WORD_W-1:0]          r;
    logic signed [psum_bw-1:0]  lane;
    r = '0;
    for (int i = 0; i < col; i++) begin
      lane = q[i*psum_bw +: psum_bw];
      r[i*psum_bw +: psum_bw] = (lane < 0) ? '0 : lane;
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_addr_d  = out_addr_q;
    done_d      = 1'b0;
    accept      = 1'b0;
    in_ready    = 1'b0;
    sram_cen    = 1'b1;
    sram_wen    = 1'b1;
    sram_a      = '0;
    sram_d      = '0;
    case (state_q)
      IDLE: begin
        // rdy_q holds the controller off until the first clock after reset release
        if (rdy_q) begin
          in_ready = 1'b1;
          if (drain_start) begin
            rd_addr_d = drain_base;
            cnt_d     = drain_len;
            if (drain_len == '0) done_d = 1'b1;
            else                 state_d = DRAIN;
          end else if (in_valid) begin
            accept   = 1'b1;
            sram_cen = 1'b0;
            sram_a   = in_addr;
            state_d  = ACC_WR;
          end
        end
      end
      ACC_WR: begin
        sram_cen = 1'b0;
        sram_wen = 1'b0;
        sram_a   = addr_q;
        sram_d   = acc_word(sram_q, data_q, first_q);
        state_d  = IDLE;
      end
      DRAIN: begin
        sram_cen    = 1'b0;
        sram_a      = rd_addr_q;
        rd_addr_d   = rd_addr_q + 1'b1;
        cnt_d       = cnt_q - 1'b1;
        out_valid_d = 1'b1;
        out_addr_d  = rd_addr_q;
        if (cnt_q == (addr_bw+1)'(1)) begin
          done_d  = 1'b1;
          state_d = DRAIN_LAST;
        end
      end
      DRAIN_LAST: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      rd_addr_q   <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      rd_addr_q   <= rd_addr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= in_addr;
      first_q <= in_first;
      data_q  <= in_data;
    end
  end

  // The bank returns q the cycle after the read, which is exactly when out_valid is up.
  assign out_data   = out_valid_q ? relu_word(sram_q) : '0;
  assign out_valid  = out_valid_q;
  assign out_addr   = out_addr_q;
  assign drain_done = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_psum_rmw_accumulator.sv
// Scoreboard bench for psum_rmw_accumulator with a behavioural 2048-word bank model.
module tb_psum_rmw_accumulator;

  typedef logic [255:0] vec_t;
  typedef struct { logic [10:0] addr; vec_t data; } wr_t;
  typedef struct { logic valid; logic [10:0] addr; vec_t data; logic done; } out_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_first;
  logic [10:0] in_addr;
  vec_t        in_data;
  logic        drain_start;
  logic [10:0] drain_base;
  logic [11:0] drain_len;
  logic        out_valid, drain_done, busy;
  logic [10:0] out_addr;
  vec_t        out_data;
  logic        sram_cen, sram_wen;
  logic [10:0] sram_a;
  vec_t        sram_d, sram_q;

  vec_t mem [0:2047];

  wr_t  wq[$];
  out_t oq[$];
  wr_t  we;
  out_t oe;
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;

  always #5 clk = ~clk;

  psum_rmw_accumulator #(.col(8), .psum_bw(32), .addr_bw(11)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_first(in_first), .in_data(in_data),
    .drain_start(drain_start), .drain_base(drain_base), .drain_len(drain_len),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
    .drain_done(drain_done), .busy(busy),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      else           sram_q      <= mem[sram_a];
    end
  end

  task automatic chk(input string nm, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] b, input logic [31:0] s);
    vec_t v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = b + s * 32'(i);
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (!sram_cen && !sram_wen) begin
        wr_count++;
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected got write to %0d expected none", sram_a);
        end else begin
          we = wq.pop_front();
          chki("wr_addr", int'(sram_a), int'(we.addr));
          chk("wr_data", sram_d, we.data);
        end
      end
      if (out_valid || drain_done) begin
        if (oq.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected got valid=%0b done=%0b expected none", out_valid, drain_done);
        end else begin
          oe = oq.pop_front();
          chki("out_valid", int'(out_valid), int'(oe.valid));
          chki("drain_done", int'(drain_done), int'(oe.done));
          if (oe.valid) begin
            chki("out_addr", int'(out_addr), int'(oe.addr));
            chk("out_data", out_data, oe.data);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    chki(nm, int'(in_ready), 1);
  endtask

  task automatic acc(input logic [10:0] a, input logic f, input vec_t d, input vec_t exp);
    in_valid = 1'b1; in_addr = a; in_first = f; in_data = d;
    wait_ready("acc_wait");
    wq.push_back('{a, exp});
    tick;
    in_valid = 1'b0;
    tick;
  endtask

  task automatic drain(input logic [10:0] base, input int len);
    int vcnt = 0;
    int done_c = -1;
    wait_ready("drain_wait");
    drain_start = 1'b1; drain_base = base; drain_len = 12'(len);
    tick;
    drain_start = 1'b0;
    for (int c = 1; c <= len + 6; c++) begin
      if (out_valid) vcnt++;
      if (drain_done) begin done_c = c; break; end
      tick;
    end
    chki("drain_done_cycle", done_c, len + 1);
    chki("drain_valid_count", vcnt, len);
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] a4 [4];
    int          wr0;
    int          r;
    int          n;
    logic        seen_done;
    vec_t        va, vb;

    reset_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_first = 1'b0; in_data = '0;
    drain_start = 1'b0; drain_base = '0; drain_len = '0;
    #22;
    chki("rst_in_ready", int'(in_ready), 0);
    chki("rst_cen", int'(sram_cen), 1);
    chki("rst_wen", int'(sram_wen), 1);
    chki("rst_out_valid", int'(out_valid), 0);
    chki("rst_drain_done", int'(drain_done), 0);
    chki("rst_busy", int'(busy), 0);
    chki("rst_sram_a", int'(sram_a), 0);
    chk("rst_sram_d", sram_d, '0);
    chki("rst_out_addr", int'(out_addr), 0);
    chk("rst_out_data", out_data, '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chki("rel_in_ready_before_clk", int'(in_ready), 0);
    tick;
    chki("rel_in_ready_after_clk", int'(in_ready), 1);

    // overwrite then accumulate, drain one word
    acc(11'd5, 1'b1, mk(32'd1, 32'd1), mk(32'd1, 32'd1));
    acc(11'd5, 1'b0, mk(32'd10, 32'd0), mk(32'd11, 32'd1));
    oq.push_back('{1'b1, 11'd5, mk(32'd11, 32'd1), 1'b1});
    drain(11'd5, 1);

    // in_valid held high across four requests
    wr0 = wr_count; r = 0;
    in_valid = 1'b1; in_first = 1'b1; in_addr = 11'd10; in_data = mk(32'd160, 32'd1);
    for (int c = 0; c < 8; c++) begin
      chki($sformatf("b2b_ready_%0d", c), int'(in_ready), (c % 2 == 0) ? 1 : 0);
      if (in_ready) begin
        wq.push_back('{in_addr, in_data});
        r++;
      end
      tick;
      if (r < 4) begin
        in_addr = 11'(10 + r); in_data = mk(32'((10 + r) * 16), 32'd1);
      end else in_valid = 1'b0;
    end
    chki("b2b_write_count", wr_count - wr0, 4);

    // lane wrap and ReLU
    va = {{7{32'd5}}, 32'h7FFFFFFF};
    vb = {{6{32'hFFFFFFF6}}, 32'd3, 32'd1};
    acc(11'd100, 1'b1, va, va);
    acc(11'd100, 1'b0, vb, {{6{32'hFFFFFFFB}}, 32'd8, 32'h80000000});
    oq.push_back('{1'b1, 11'd100, {{6{32'd0}}, 32'd8, 32'd0}, 1'b1});
    drain(11'd100, 1);

    // drain across the top of the address space
    a4[0] = 11'd2046; a4[1] = 11'd2047; a4[2] = 11'd0; a4[3] = 11'd1;
    for (int k = 0; k < 4; k++)
      acc(a4[k], 1'b1, mk(32'(100 * k + 7), 32'd3), mk(32'(100 * k + 7), 32'd3));
    for (int k = 0; k < 4; k++)
      oq.push_back('{1'b1, a4[k], mk(32'(100 * k + 7), 32'd3), (k == 3)});
    drain(11'd2046, 4);
    oq.push_back('{1'b0, 11'd0, '0, 1'b1});
    drain(11'd0, 0);

    // drain_start beats in_valid in the same cycle
    oq.push_back('{1'b1, 11'd5, mk(32'd11, 32'd1), 1'b1});
    drain_start = 1'b1; drain_base = 11'd5; drain_len = 12'd1;
    in_valid = 1'b1; in_addr = 11'd20; in_first = 1'b1; in_data = mk(32'd100, 32'd1);
    chki("prio_ready", int'(in_ready), 1);
    tick;
    drain_start = 1'b0;
    seen_done = 1'b0; n = 0;
    while (!in_ready && n < 20) begin
      if (drain_done) seen_done = 1'b1;
      tick; n++;
    end
    chki("prio_done_before_accept", int'(seen_done), 1);
    chki("prio_ready_after_drain", int'(in_ready), 1);
    wq.push_back('{11'd20, mk(32'd100, 32'd1)});
    tick;
    in_valid = 1'b0;
    tick;

    // reset during ACC_WR
    in_valid = 1'b1; in_addr = 11'd30; in_first = 1'b1; in_data = mk(32'd1, 32'd0);
    tick;
    in_valid = 1'b0;
    chki("abort_acc_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chki("abort_acc_cen", int'(sram_cen), 1);
    chki("abort_acc_out_valid", int'(out_valid), 0);
    tick; tick;
    reset_n = 1'b1;
    chki("abort_acc_ready_held", int'(in_ready), 0);
    tick;
    chki("abort_acc_ready", int'(in_ready), 1);

    // reset during DRAIN
    drain_start = 1'b1; drain_base = 11'd2046; drain_len = 12'd4;
    tick;
    drain_start = 1'b0;
    tick;
    chki("abort_drain_valid_before", int'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    chki("abort_drain_cen", int'(sram_cen), 1);
    chki("abort_drain_out_valid", int'(out_valid), 0);
    chki("abort_drain_busy", int'(busy), 0);
    tick; tick;
    reset_n = 1'b1;
    tick;
    chki("abort_drain_ready", int'(in_ready), 1);

    repeat (3) tick;
    chki("wq_empty", wq.size(), 0);
    chki("oq_empty", oq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
